// File: rtl/spi_responder.sv
// SPI mode-0 responder: synchronised sck/cs/mosi, byte RX/TX FIFOs, sticky error flags.
// Optional feature macro: SPI_RESP_ECHO_EN (on TX underrun send last received byte instead of FILL_BYTE).
module spi_responder #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       tx_wr,
    input  logic [7:0] tx_din,
    output logic       tx_full,
    output logic       tx_empty,
    input  logic       rx_rd,
    output logic [7:0] rx_dout,
    output logic       rx_avail,
    output logic       busy,
    output logic       frame_done,
    output logic       abort,
    output logic       rx_ovf,
    output logic       tx_udf,
    input  logic       clr_flags,
    output logic [1:0] dbg_state,
    output logic [2:0] dbg_bit_cnt
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic sck_prev_q, cs_prev_q;
    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    // The cs chain resets low so a reset released while cs is already low cannot look like a fresh cs fall.
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    state_t      state_q;
    logic [7:0]  tx_sr_q, rx_sr_q;
    logic [2:0]  bit_cnt_q;
    logic        miso_oe_q, busy_q, frame_done_q, abort_q, rx_ovf_q, tx_udf_q;

    logic [7:0]  tx_mem_q [FIFO_DEPTH];
    logic [7:0]  rx_mem_q [FIFO_DEPTH];
    logic [AW:0] tx_wr_ptr_q, tx_rd_ptr_q, rx_wr_ptr_q, rx_rd_ptr_q;
    logic [AW:0] tx_cnt, rx_cnt;
    logic        rx_full;

    assign tx_cnt   = tx_wr_ptr_q - tx_rd_ptr_q;
    assign rx_cnt   = rx_wr_ptr_q - rx_rd_ptr_q;
    assign tx_full  = tx_cnt[AW];
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = rx_cnt[AW];
    assign rx_avail = (rx_cnt != '0);
    assign rx_dout  = rx_avail ? rx_mem_q[rx_rd_ptr_q[AW-1:0]] : 8'h00;

    logic       end_frame, shift_act, byte_done, tx_load, tx_pop, tx_push;
    logic       rx_pop, rx_push, rx_drop;
    logic [7:0] rx_byte, fill_byte, tx_next;

    // cs rise pre-empts any sck edge seen in the same cycle.
    assign end_frame = (state_q != IDLE) & cs_rise;
    assign shift_act = (state_q == SHIFT) & ~cs_rise;
    assign byte_done = shift_act & sck_rise & (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_sr_q[6:0], mosi_s};
    assign tx_load   = ((state_q == LOAD) & ~cs_rise) | (shift_act & sck_fall & (bit_cnt_q == 3'd0));
    assign tx_pop    = tx_load & ~tx_empty;
    assign tx_push   = tx_wr & (~tx_full | tx_pop);
    assign rx_pop    = rx_rd & rx_avail;
    assign rx_push   = byte_done & (~rx_full | rx_pop);
    assign rx_drop   = byte_done & rx_full & ~rx_pop;
    assign tx_next   = tx_empty ? fill_byte : tx_mem_q[tx_rd_ptr_q[AW-1:0]];

`ifdef SPI_RESP_ECHO_EN
    logic [7:0] last_rx_q;
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n)         last_rx_q <= FILL_BYTE;
        else if (byte_done) last_rx_q <= rx_byte;
    end
    assign fill_byte = last_rx_q;
`else
    assign fill_byte = FILL_BYTE;
`endif

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PTR_ONE;
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PTR_ONE;
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PTR_ONE;
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wr_ptr_q[AW-1:0]] <= tx_din;
        if (rx_push) rx_mem_q[rx_wr_ptr_q[AW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            tx_sr_q      <= 8'h00;
            rx_sr_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            miso_oe_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            rx_ovf_q     <= 1'b0;
            tx_udf_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
            rx_ovf_q     <= rx_drop | (rx_ovf_q & ~clr_flags);
            tx_udf_q     <= (tx_load & tx_empty) | (tx_udf_q & ~clr_flags);
            if (end_frame) begin
                state_q      <= IDLE;
                miso_oe_q    <= 1'b0;
                busy_q       <= 1'b0;
                frame_done_q <= (bit_cnt_q == 3'd0);
                abort_q      <= (bit_cnt_q != 3'd0);
                bit_cnt_q    <= 3'd0;
                rx_sr_q      <= 8'h00;
            end else begin
                case (state_q)
                    IDLE: if (cs_fall) state_q <= LOAD;
                    LOAD: begin
                        tx_sr_q   <= tx_next;
                        miso_oe_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                    SHIFT: begin
                        if (sck_rise) begin
                            rx_sr_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (sck_fall) begin
                            tx_sr_q <= tx_load ? tx_next : {tx_sr_q[6:0], 1'b0};
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign miso        = miso_oe_q & tx_sr_q[7];
    assign miso_oe     = miso_oe_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign abort       = abort_q;
    assign rx_ovf      = rx_ovf_q;
    assign tx_udf      = tx_udf_q;
    assign dbg_state   = state_q;
    assign dbg_bit_cnt = bit_cnt_q;
endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: vector table of single-byte frames plus hand-written frame sequences.
module tb_spi_responder;
    localparam int HALF = 6;

    logic       clk = 1'b0, Rst_n = 1'b0, sck = 1'b0, cs = 1'b1, mosi = 1'b0;
    logic       tx_wr = 1'b0, rx_rd = 1'b0, clr_flags = 1'b0;
    logic [7:0] tx_din = 8'h00;
    logic       miso, miso_oe, tx_full, tx_empty, rx_avail, busy, frame_done, abort, rx_ovf, tx_udf;
    logic [7:0] rx_dout;
    logic [1:0] dbg_state;
    logic [2:0] dbg_bit_cnt;

    int         total = 0, bad = 0, fd_cnt = 0, ab_cnt = 0;
    logic [7:0] model_last = 8'hFF;
    logic [7:0] exp_q[$];

    spi_responder dut (
        .clk(clk), .Rst_n(Rst_n), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .tx_wr(tx_wr), .tx_din(tx_din), .tx_full(tx_full), .tx_empty(tx_empty),
        .rx_rd(rx_rd), .rx_dout(rx_dout), .rx_avail(rx_avail), .busy(busy),
        .frame_done(frame_done), .abort(abort), .rx_ovf(rx_ovf), .tx_udf(tx_udf),
        .clr_flags(clr_flags), .dbg_state(dbg_state), .dbg_bit_cnt(dbg_bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (abort) ab_cnt++;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: time limit reached, required finish before 1 ms");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] fill_exp();
`ifdef SPI_RESP_ECHO_EN
        return model_last;
`else
        return 8'hFF;
`endif
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_tx(input logic [7:0] b);
        @(negedge clk); tx_din = b; tx_wr = 1'b1;
        @(negedge clk); tx_wr = 1'b0;
    endtask

    task automatic pop_rx();
        @(negedge clk); rx_rd = 1'b1;
        @(negedge clk); rx_rd = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); clr_flags = 1'b1;
        @(negedge clk); clr_flags = 1'b0;
    endtask

    task automatic cs_begin();
        @(negedge clk); cs = 1'b0;
        wait_n(8);
    endtask

    task automatic cs_end();
        wait_n(HALF); cs = 1'b1;
        wait_n(8);
    endtask

    // Mode 0: mosi set while sck low, miso sampled just before the rise.
    task automatic spi_byte(input logic [7:0] mo, input bit rd_last, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            wait_n(HALF);
            mi[i] = miso;
            sck = 1'b1;
            if (rd_last && i == 0) begin
                wait_n(2); rx_rd = 1'b1;
                wait_n(1); rx_rd = 1'b0;
                wait_n(HALF - 3);
            end else begin
                wait_n(HALF);
            end
            sck = 1'b0;
        end
        model_last = mo;
    endtask

    task automatic sck_bits(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = i[0];
            wait_n(HALF); sck = 1'b1;
            wait_n(HALF); sck = 1'b0;
        end
    endtask

    task automatic drain_check(input string name);
        while (exp_q.size() > 0) begin
            check(name, {24'h0, rx_dout}, {24'h0, exp_q.pop_front()});
            pop_rx();
        end
        check({name, "_empty"}, {31'h0, rx_avail}, 32'h0);
    endtask

    typedef struct {
        bit         push;
        logic [7:0] txb;
        logic [7:0] mo;
        logic [7:0] exp_mi;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] mi;
    int         fd0, ab0;

    initial begin
        vecs[0] = '{1'b1, 8'hC6, 8'h5A, 8'hC6};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF};
        vecs[2] = '{1'b0, 8'h00, 8'h3C, 8'hFF};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81};
        vecs[4] = '{1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[5] = '{1'b1, 8'hFF, 8'h00, 8'hFF};

        wait_n(3);
        check("rst_miso", {31'h0, miso}, 32'h0);
        check("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_flags", {28'h0, frame_done, abort, rx_ovf, tx_udf}, 32'h0);
        check("rst_rx", {23'h0, rx_avail, rx_dout}, 32'h0);
        check("rst_tx", {30'h0, tx_full, tx_empty}, 32'h1);
        check("rst_state", {27'h0, dbg_state, dbg_bit_cnt}, 32'h0);
        Rst_n = 1'b1;
        wait_n(8);

        // Basic two-byte exchange
        push_tx(8'hA5); push_tx(8'h3C);
        check("basic_tx_not_empty", {31'h0, tx_empty}, 32'h0);
        fd0 = fd_cnt; ab0 = ab_cnt;
        cs_begin();
        check("basic_busy_oe", {30'h0, busy, miso_oe}, 32'h3);
        check("basic_state", {30'h0, dbg_state}, 32'h2);
        spi_byte(8'h11, 1'b0, mi);
        check("basic_miso0", {24'h0, mi}, 32'hA5);
        wait_n(4);
        check("basic_udf_mid", {31'h0, tx_udf}, 32'h0);
        check("basic_tx_drained", {31'h0, tx_empty}, 32'h1);
        spi_byte(8'h22, 1'b0, mi);
        check("basic_miso1", {24'h0, mi}, 32'h3C);
        cs_end();
        check("basic_frame_done", fd_cnt - fd0, 32'd1);
        check("basic_no_abort", ab_cnt - ab0, 32'd0);
        check("basic_idle", {30'h0, busy, miso_oe}, 32'h0);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22);
        drain_check("basic_rx");

        // Table of single-byte frames, including TX underrun
        for (int v = 0; v < 6; v++) begin
            logic [7:0] exp_mi;
            exp_mi = vecs[v].exp_mi;
            if (!vecs[v].push) exp_mi = fill_exp();
            pulse_clr();
            if (vecs[v].push) push_tx(vecs[v].txb);
            fd0 = fd_cnt;
            cs_begin();
            check($sformatf("vec%0d_udf_load", v), {31'h0, tx_udf}, {31'h0, !vecs[v].push});
            spi_byte(vecs[v].mo, 1'b0, mi);
            check($sformatf("vec%0d_miso", v), {24'h0, mi}, {24'h0, exp_mi});
            cs_end();
            check($sformatf("vec%0d_frame_done", v), fd_cnt - fd0, 32'd1);
            exp_q.push_back(vecs[v].mo);
            drain_check($sformatf("vec%0d_rx", v));
        end

        // RX overflow: FIFO_DEPTH+1 bytes without reading
        pulse_clr();
        cs_begin();
        for (int i = 0; i < 9; i++) begin
            spi_byte(8'h10 + 8'(i), 1'b0, mi);
            if (i < 8) exp_q.push_back(8'h10 + 8'(i));
            if (i == 7) check("ovf_full_no_flag", {31'h0, rx_ovf}, 32'h0);
        end
        check("ovf_set", {31'h0, rx_ovf}, 32'h1);
        cs_end();
        check("ovf_sticky", {31'h0, rx_ovf}, 32'h1);
        drain_check("ovf_rx");
        pulse_clr();
        check("ovf_cleared", {31'h0, rx_ovf}, 32'h0);

        // Abort after 5 sck pulses, then a clean frame
        fd0 = fd_cnt; ab0 = ab_cnt;
        cs_begin();
        sck_bits(5);
        check("abort_bitcnt_mid", {29'h0, dbg_bit_cnt}, 32'd5);
        cs_end();
        check("abort_pulse", ab_cnt - ab0, 32'd1);
        check("abort_no_done", fd_cnt - fd0, 32'd0);
        check("abort_no_rx", {31'h0, rx_avail}, 32'h0);
        check("abort_oe_bitcnt", {28'h0, miso_oe, dbg_bit_cnt}, 32'h0);
        push_tx(8'h6D);
        cs_begin();
        spi_byte(8'hC3, 1'b0, mi);
        check("after_abort_miso", {24'h0, mi}, 32'h6D);
        cs_end();
        exp_q.push_back(8'hC3);
        drain_check("after_abort_rx");

        // TX full with ignored write; RX full with simultaneous pop at a push
        pulse_clr();
        for (int i = 0; i < 8; i++) push_tx(8'hB0 + 8'(i));
        check("txfull_set", {31'h0, tx_full}, 32'h1);
        push_tx(8'hEE);
        check("txfull_ignored", {31'h0, tx_full}, 32'h1);
        cs_begin();
        for (int i = 0; i < 8; i++) begin
            spi_byte(8'h20 + 8'(i), 1'b0, mi);
            check($sformatf("bnd_miso%0d", i), {24'h0, mi}, {24'h0, 8'hB0 + 8'(i)});
            if (i > 0) exp_q.push_back(8'h20 + 8'(i));
        end
        begin
            logic [7:0] f;
            f = fill_exp();
            spi_byte(8'h28, 1'b1, mi);
            check("bnd_miso_fill", {24'h0, mi}, {24'h0, f});
        end
        exp_q.push_back(8'h28);
        check("bnd_no_ovf", {31'h0, rx_ovf}, 32'h0);
        cs_end();
        drain_check("bnd_rx");

        // Asynchronous reset during bit 4
        push_tx(8'h99); push_tx(8'h98);
        cs_begin();
        sck_bits(3);
        mosi = 1'b1;
        wait_n(HALF); sck = 1'b1;
        wait_n(2);
        #3 Rst_n = 1'b0;
        #1;
        check("mrst_oe_busy", {30'h0, miso_oe, busy}, 32'h0);
        check("mrst_miso", {31'h0, miso}, 32'h0);
        check("mrst_tx_empty", {31'h0, tx_empty}, 32'h1);
        check("mrst_state", {27'h0, dbg_state, dbg_bit_cnt}, 32'h0);
        model_last = 8'hFF;
        wait_n(2); Rst_n = 1'b1;
        wait_n(HALF); sck = 1'b0;
        wait_n(20);
        check("mrst_no_load", {30'h0, dbg_state}, 32'h0);
        check("mrst_no_oe", {30'h0, miso_oe, busy}, 32'h0);
        cs = 1'b1;
        wait_n(8);
        push_tx(8'h9E);
        cs_begin();
        spi_byte(8'h77, 1'b0, mi);
        check("mrst_fresh_miso", {24'h0, mi}, 32'h9E);
        cs_end();
        exp_q.push_back(8'h77);
        drain_check("mrst_fresh_rx");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
